// File: rtl/sr_col_collect.sv
// sr_col_collect: column collector with optional inverse-ShiftRows scatter.
//
// Accepts one 32-bit AES state column per handshake, four beats per frame, and
// assembles a 128-bit state. Each row byte lands either at its own position or
// at its InvShiftRows position. The completed state sits in a registered output
// with a valid/ready handshake, and the next frame can be collected while the
// previous one waits.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   clear      synchronous frame abort (counter and assembly buffer to 0)
//   shift_en   1 = InvShiftRows scatter, sampled on the column-0 beat only
//   in_valid   column beat valid
//   in_ready   collector can accept a beat
//   in_1..in_4 rows 0..3 of the incoming column
//   col_idx    column the next accepted beat writes
//   state_out  assembled state, byte k = [127-8k -: 8] = row k%4, column k/4
//   out_valid  state_out holds a complete, unconsumed state
//   out_ready  consumer takes state_out
module sr_col_collect (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         shift_en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_1,
   input  logic [7:0]   in_2,
   input  logic [7:0]   in_3,
   input  logic [7:0]   in_4,
   output logic [1:0]   col_idx,
   output logic [127:0] state_out,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [1:0]   col_q, col_d;
   logic         mode_q, mode_d;
   logic [127:0] asm_q, asm_d;
   logic [127:0] out_q, out_d;
   logic         out_valid_q, out_valid_d;

   logic         accept;
   logic         eff_mode;
   logic [7:0]   row_byte [4];
   logic [3:0]   dest_idx [4];
   logic [127:0] asm_wr;

   // Only the final beat can stall: it needs the output register to be free.
   assign in_ready = !((col_q == 2'd3) && out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready;

   // The column-0 beat uses the live shift_en; later beats use the latched mode.
   assign eff_mode = (col_q == 2'd0) ? shift_en : mode_q;

   always_comb begin
      row_byte[0] = in_1;
      row_byte[1] = in_2;
      row_byte[2] = in_3;
      row_byte[3] = in_4;
   end

   // Destination byte index: column (c + r) mod 4 in scatter mode, c otherwise.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         if (eff_mode) begin
            dest_idx[r] = {col_q + 2'(r), 2'(r)};
         end else begin
            dest_idx[r] = {col_q, 2'(r)};
         end
      end
   end

   // Assembly buffer with the current beat's bytes merged in.
   always_comb begin
      asm_wr = asm_q;
      for (int k = 0; k < 16; k++) begin
         for (int r = 0; r < 4; r++) begin
            if (dest_idx[r] == 4'(k)) begin
               asm_wr[127-8*k -: 8] = row_byte[r];
            end
         end
      end
   end

   always_comb begin
      col_d       = col_q;
      mode_d      = mode_q;
      asm_d       = asm_q;
      out_d       = out_q;
      out_valid_d = out_valid_q && !out_ready;
      if (clear) begin
         // Abort drops any beat offered this cycle; the output side is left alone.
         col_d = 2'd0;
         asm_d = '0;
      end else if (accept) begin
         if (col_q == 2'd0) begin
            mode_d = shift_en;
         end
         if (col_q == 2'd3) begin
            // A same-cycle load beats the consumer's take.
            out_d       = asm_wr;
            out_valid_d = 1'b1;
            asm_d       = '0;
            col_d       = 2'd0;
         end else begin
            asm_d = asm_wr;
            col_d = col_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         col_q       <= 2'd0;
         mode_q      <= 1'b0;
         asm_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         mode_q      <= mode_d;
         asm_q       <= asm_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign col_idx   = col_q;
   assign state_out = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sr_col_collect.sv
// Directed testbench for sr_col_collect.
module tb_sr_col_collect;

   logic         clk;
   logic         reset;
   logic         clear;
   logic         shift_en;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_1, in_2, in_3, in_4;
   logic [1:0]   col_idx;
   logic [127:0] state_out;
   logic         out_valid;
   logic         out_ready;

   int errors;
   int checks;

   localparam logic [127:0] Seq      = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] SeqInv   = 128'h000D0A0704010E0B0805020F0C090603;
   localparam logic [127:0] Seq2     = 128'h101112131415161718191A1B1C1D1E1F;
   localparam logic [127:0] RandS    = 128'h3243F6A8885A308D313198A2E0370734;

   sr_col_collect u_dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .shift_en  (shift_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_1      (in_1),
      .in_2      (in_2),
      .in_3      (in_3),
      .in_4      (in_4),
      .col_idx   (col_idx),
      .state_out (state_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_col(input logic [127:0] frame, input int c);
      logic [31:0] col;
      col  = frame[127-32*c -: 32];
      in_1 = col[31:24];
      in_2 = col[23:16];
      in_3 = col[15:8];
      in_4 = col[7:0];
   endtask

   // Offer column c of frame until accepted (bounded wait).
   task automatic send_beat(input logic [127:0] frame, input int c, input logic se);
      int n;
      set_col(frame, c);
      shift_en = se;
      in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n == 50) check_eq("in_ready_timeout", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [127:0] frame, input logic [3:0] se);
      for (int c = 0; c < 4; c++) send_beat(frame, c, se[3-c]);
   endtask

   initial begin
      logic [127:0] slicer_frame;
      errors    = 0;
      checks    = 0;
      reset     = 1'b0;
      clear     = 1'b0;
      shift_en  = 1'b0;
      in_valid  = 1'b0;
      in_1      = 8'h00;
      in_2      = 8'h00;
      in_3      = 8'h00;
      in_4      = 8'h00;
      out_ready = 1'b1;

      // Reset state
      step();
      step();
      reset = 1'b1;
      check_eq("rst_state_out", state_out, 128'd0);
      check_eq("rst_out_valid", 128'(out_valid), 128'd0);
      check_eq("rst_col_idx", 128'(col_idx), 128'd0);
      check_eq("rst_in_ready", 128'(in_ready), 128'd1);

      // Straight frame, out_valid for exactly one cycle
      send_beat(Seq, 0, 1'b0);
      check_eq("straight_col_after_b0", 128'(col_idx), 128'd1);
      check_eq("straight_no_early_valid", 128'(out_valid), 128'd0);
      send_beat(Seq, 1, 1'b0);
      send_beat(Seq, 2, 1'b0);
      send_beat(Seq, 3, 1'b0);
      check_eq("straight_valid", 128'(out_valid), 128'd1);
      check_eq("straight_state", state_out, Seq);
      check_eq("straight_col_wrap", 128'(col_idx), 128'd0);
      step();
      check_eq("straight_valid_one_cycle", 128'(out_valid), 128'd0);

      // Inverse scatter; shift_en toggles on beats 1..3 are ignored
      send_frame(Seq, 4'b1010);
      check_eq("inv_valid", 128'(out_valid), 128'd1);
      check_eq("inv_state", state_out, SeqInv);
      send_frame(Seq, 4'b0111);
      check_eq("straight_toggle_state", state_out, Seq);
      step();

      // Backpressure: frame 2 collects while frame 1 waits
      out_ready = 1'b0;
      send_frame(Seq, 4'b0000);
      step();
      step();
      check_eq("bp_f1_held_valid", 128'(out_valid), 128'd1);
      check_eq("bp_f1_held_state", state_out, Seq);
      send_beat(Seq, 0, 1'b1);
      send_beat(Seq, 1, 1'b0);
      send_beat(Seq, 2, 1'b0);
      check_eq("bp_col3", 128'(col_idx), 128'd3);
      check_eq("bp_in_ready_low", 128'(in_ready), 128'd0);
      set_col(Seq, 3);
      in_valid = 1'b1;
      step();
      check_eq("bp_beat3_stalled", 128'(col_idx), 128'd3);
      check_eq("bp_f1_stable", state_out, Seq);
      out_ready = 1'b1;
      #1;
      check_eq("bp_in_ready_high", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0;
      check_eq("bp_handover_valid", 128'(out_valid), 128'd1);
      check_eq("bp_handover_state", state_out, SeqInv);
      step();
      check_eq("bp_drained", 128'(out_valid), 128'd0);

      // clear after beat 1 drops the in-flight beat and leaves the output intact
      out_ready = 1'b0;
      send_frame(Seq, 4'b0000);
      send_beat(Seq2, 0, 1'b0);
      send_beat(Seq2, 1, 1'b0);
      check_eq("clr_col_before", 128'(col_idx), 128'd2);
      set_col(Seq2, 2);
      in_valid = 1'b1;
      clear    = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      check_eq("clr_col_zero", 128'(col_idx), 128'd0);
      check_eq("clr_out_intact", state_out, Seq);
      check_eq("clr_valid_intact", 128'(out_valid), 128'd1);
      out_ready = 1'b1;
      step();
      send_frame(Seq2, 4'b0000);
      check_eq("clr_new_frame", state_out, Seq2);
      step();

      // Reset mid-frame with a pending output, released with in_valid high
      out_ready = 1'b0;
      send_frame(Seq2, 4'b0000);
      send_beat(Seq, 0, 1'b0);
      send_beat(Seq, 1, 1'b0);
      reset    = 1'b0;
      set_col(Seq, 0);
      shift_en = 1'b1;
      in_valid = 1'b1;
      step();
      check_eq("mrst_state_out", state_out, 128'd0);
      check_eq("mrst_out_valid", 128'(out_valid), 128'd0);
      check_eq("mrst_col_idx", 128'(col_idx), 128'd0);
      check_eq("mrst_in_ready", 128'(in_ready), 128'd1);
      reset = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("mrst_first_beat", 128'(col_idx), 128'd1);
      send_beat(Seq, 1, 1'b0);
      send_beat(Seq, 2, 1'b0);
      send_beat(Seq, 3, 1'b0);
      check_eq("mrst_frame", state_out, SeqInv);
      out_ready = 1'b1;
      step();

      // Round trip against the ShiftRows column slicer
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 4; r++) begin
            slicer_frame[127-8*(4*i+r) -: 8] = RandS[127-8*(4*((i+r)%4)+r) -: 8];
         end
      end
      send_frame(slicer_frame, 4'b1000);
      check_eq("roundtrip_valid", 128'(out_valid), 128'd1);
      check_eq("roundtrip_state", state_out, RandS);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
